dm_wait: RTL

DM_WAIT -- requirements
Module: dm_wait

---
 rtl/dm_wait.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dm_wait.sv
// Word-organised data memory with byte/halfword/word access and a fixed number of wait states.
// Accesses are accepted only in IDLE, and each one completes with a single-cycle ack pulse.
module dm_wait #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] WaitLast = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              idle, cap, enter_done, acc_bad, we;
  logic              acc_wr, acc_sgn;
  logic [1:0]        acc_size, lane;
  logic [ADDR_W+1:0] acc_addr;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       acc_wdata, word, wword;
  logic [3:0]        wmask;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign idle = (state_q == StIdle);
  assign cap  = idle && req;

  // With WAIT=0 DONE is entered on the capture edge, so use live inputs while idle.
  assign acc_wr    = idle ? wr    : wr_q;
  assign acc_size  = idle ? size  : size_q;
  assign acc_sgn   = idle ? sgn   : sgn_q;
  assign acc_addr  = idle ? addr  : addr_q;
  assign acc_wdata = idle ? wdata : wdata_q;

  assign lane    = acc_addr[1:0];
  assign widx    = acc_addr[ADDR_W+1:2];
  assign acc_bad = (acc_size == 2'b11) ||
                   ((acc_size == 2'b01) && acc_addr[0]) ||
                   ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (req) state_d = (WAIT == 0) ? StDone : StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WaitLast) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_done = (state_d == StDone) && (state_q != StDone);

  assign word   = mem_q[widx];
  assign byte_v = word[8*lane +: 8];
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata_d = rdata_q;
    if (enter_done && !acc_wr) begin
      if (acc_bad) begin
        rdata_d = 32'h0;
      end else begin
        unique case (acc_size)
          2'b00:   rdata_d = {{24{acc_sgn & byte_v[7]}}, byte_v};
          2'b01:   rdata_d = {{16{acc_sgn & half_v[15]}}, half_v};
          default: rdata_d = word;
        endcase
      end
    end
  end

  always_comb begin
    wmask = 4'b0000;
    wword = acc_wdata;
    unique case (acc_size)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  // Gating on rst keeps a store from landing on an edge where reset is held.
  assign we = enter_done && acc_wr && !acc_bad && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (cap) begin
        wr_q    <= wr;
        size_q  <= size;
        sgn_q   <= sgn;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == StDone);
  assign busy  = !idle;
  assign fault = ack && acc_bad;

endmodule
